multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter XLen, default 32, datapath width; used only to size the ALU control encoding consistently with the datapath.
REQ-002 SHALL have parameter NOps, default 6, number of ALU operations; alu_control_o width is $clog2(NOps).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port op_i, input, 7, instruction opcode from the instruction register.
REQ-006 SHALL have port funct3_i, input, 3, instruction funct3.
REQ-007 SHALL have port funct7b5_i, input, 1, instruction bit 30.
REQ-008 SHALL have port zero_i, input, 1, ALU zero flag.
REQ-009 SHALL have outputs pc_write_o, adr_src_o, mem_write_o, ir_write_o and reg_write_o, each 1 bit, as datapath enables and selects.
REQ-010 SHALL have outputs result_src_o, alu_src_a_o, alu_src_b_o and imm_src_o, each 2 bits, as datapath mux selects.
REQ-011 SHALL have output alu_control_o, $clog2(NOps) bits, the ALU operation code.

Function
REQ-012 SHALL use this ALU encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-013 SHALL use these select encodings:
- alu_src_a_o: 00 PC, 01 OldPC, 10 rs1.
- alu_src_b_o: 00 rs2, 01 imm, 10 constant 4.
- result_src_o: 00 ALUOut, 01 Data, 10 ALUResult.
- imm_src_o: 00 I, 01 S, 10 B, 11 J.
REQ-014 SHALL implement these Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-015 SHALL implement these transitions:
- FETCH always goes to DECODE.
- DECODE goes to MEMADR for op 0000011 or 0100011, to EXECUTER for 0110011, to EXECUTEI for 0010011, to JAL for 1101111, and to BEQ for 1100011.
- DECODE goes to FETCH for any other opcode, with no side effects.
REQ-016 SHALL continue the transitions as follows:
- MEMADR goes to MEMREAD if op_i[5]=0, otherwise to MEMWRITE.
- MEMREAD goes to MEMWB; MEMWB and MEMWRITE go to FETCH.
- EXECUTER, EXECUTEI and JAL go to ALUWB; ALUWB and BEQ go to FETCH.
REQ-017 SHALL drive FETCH outputs: adr_src_o=0, ir_write_o=1, alu_src_a_o=00, alu_src_b_o=10, alu op add, result_src_o=10, pc_update=1.
REQ-018 SHALL drive DECODE outputs: alu_src_a_o=01, alu_src_b_o=01, alu op add, imm_src_o=10 (branch target precompute).
REQ-019 SHALL drive MEMADR outputs: alu_src_a_o=10, alu_src_b_o=01, add; imm_src_o=01 when op_i[5]=1, otherwise 00.
REQ-020 SHALL drive MEMREAD and MEMWRITE outputs: result_src_o=00, adr_src_o=1; MEMWRITE additionally asserts mem_write_o.
REQ-021 SHALL drive MEMWB outputs: result_src_o=01, reg_write_o=1.
REQ-022 SHALL drive EXECUTER/EXECUTEI outputs: alu_src_a_o=10, alu_src_b_o=00 (R) or 01 (I, with imm_src_o=00), alu op funct-decoded.
REQ-023 SHALL drive ALUWB outputs: result_src_o=00, reg_write_o=1.
REQ-024 SHALL drive BEQ outputs: alu_src_a_o=10, alu_src_b_o=00, alu op sub, result_src_o=00, branch=1.
REQ-025 SHALL drive JAL outputs: alu_src_a_o=01, alu_src_b_o=10, add, result_src_o=00, pc_update=1, imm_src_o=11.
REQ-026 SHALL compute pc_write_o = pc_update | (branch & zero_i) combinationally within the same cycle.
REQ-027 SHALL decode the funct-decoded ALU op from funct3_i as follows:
- 000 gives sub if op_i[5]&funct7b5_i, otherwise add.
- 010 gives slt; 100 gives xor; 110 gives or; 111 gives and.
- Any other value gives add.
REQ-028 SHALL drive all enables and selects to 0 in any state that does not list them; no latches.
REQ-029 SHALL give these instruction latencies: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4, unsupported opcode 2.

Reset
REQ-030 SHALL enter FETCH immediately and asynchronously when rst_ni is low, regardless of the current state.
REQ-031 SHALL make outputs equal the FETCH decode while in reset, except that ir_write_o and pc_write_o are forced to 0 while rst_ni=0.
REQ-032 SHALL begin fetching on the first rising clk_i after rst_ni deasserts; a reset mid-instruction abandons that instruction, with no partial write issued after the reset.

Structure
REQ-033 SHALL place the state enum, the alu_control encodings, the opcode constants and the select encodings in a shared package, riscv_pkg.
REQ-034 SHALL implement the funct3/funct7 to alu_control mapping in a combinational sub-module named alu_decoder, instantiated once.

Verification
REQ-035 SHALL verify lw (op 0000011): after reset the state sequence is FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write_o=1 only in cycle 5, with result_src_o=01.
REQ-036 SHALL verify R-type sub (op 0110011, funct3 000, funct7b5 1): in EXECUTER alu_control_o=001; ALUWB asserts reg_write_o; the next state is FETCH.
REQ-037 SHALL verify beq: with zero_i=1 in BEQ, pc_write_o=1 for exactly that cycle; with zero_i=0, pc_write_o=0 and the FSM returns to FETCH.
REQ-038 SHALL verify sw (op 0100011): MEMADR has imm_src_o=01; MEMWRITE has mem_write_o=1 and adr_src_o=1; the next state is FETCH.
REQ-039 SHALL verify that an unsupported opcode 0000000 goes DECODE to FETCH, with mem_write_o and reg_write_o 0 throughout.
REQ-040 SHALL verify that rst_ni driven low mid-cycle in MEMWRITE returns the FSM to FETCH asynchronously and drops mem_write_o to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, ALU operation codes, opcodes and datapath select values.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_DATA     = 2'b01;
  localparam logic [1:0] RES_ALURES   = 2'b10;

  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_S        = 2'b01;
  localparam logic [1:0] IMM_B        = 2'b10;
  localparam logic [1:0] IMM_J        = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 bit 30 to an ALU operation for R- and I-type execute.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_op_e    alu_op
);

  // Only R-type (op5=1) with bit 30 set is a subtract; addi never is.
  always_comb begin
    alu_op = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_op = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath; issues enables and
// mux selects per state, plus a same-cycle branch-taken PC write.
//
// state      | meaning
// FETCH      | read instruction, PC <= PC+4
// DECODE     | read registers, precompute branch target
// MEMADR     | compute load/store address
// MEMREAD    | read data memory
// MEMWB      | write loaded data to rd
// MEMWRITE   | write rs2 to data memory
// EXECUTER   | R-type ALU op
// EXECUTEI   | I-type ALU op
// ALUWB      | write ALU result to rd
// BEQ        | compare, take branch on zero
// JAL        | PC <= target, compute link
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter  int XLen = 32,
  parameter  int NOps = 6,
  localparam int AluW = (XLen > 0) ? $clog2(NOps) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [6:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic            zero_i,
  output logic            pc_write_o,
  output logic            adr_src_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic [1:0]      result_src_o,
  output logic [1:0]      alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      imm_src_o,
  output logic [AluW-1:0] alu_control_o
);

  state_e  state, state_next;
  alu_op_e funct_op, alu_op;
  logic    pc_update, branch, ir_write;

  alu_decoder u_alu_decoder (
    .funct3   (funct3_i),
    .funct7b5 (funct7b5_i),
    .op5      (op_i[5]),
    .alu_op   (funct_op)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = S_FETCH;
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_write     = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_RS2;
    imm_src_o    = IMM_I;
    alu_op       = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        state_next   = S_DECODE;
        ir_write     = 1'b1;
        alu_src_b_o  = SRC_B_FOUR;
        result_src_o = RES_ALURES;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        imm_src_o   = IMM_B;
        unique case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_next  = op_i[5] ? S_MEMWRITE : S_MEMREAD;
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        imm_src_o   = op_i[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        state_next = S_MEMWB;
        adr_src_o  = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = RES_DATA;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXECUTER: begin
        state_next  = S_ALUWB;
        alu_src_a_o = SRC_A_RS1;
        alu_op      = funct_op;
      end
      S_EXECUTEI: begin
        state_next  = S_ALUWB;
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op      = funct_op;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_BEQ: begin
        alu_src_a_o = SRC_A_RS1;
        alu_op      = ALU_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        state_next  = S_ALUWB;
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_FOUR;
        imm_src_o   = IMM_J;
        pc_update   = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset already holds FETCH; only the two architectural writes are masked.
  assign ir_write_o    = rst_ni & ir_write;
  assign pc_write_o    = rst_ni & (pc_update | (branch & zero_i));
  assign alu_control_o = AluW'(alu_op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Random instruction stream checked cycle-by-cycle against per-instruction
// expected output traces, plus reset and mid-MEMWRITE reset checks.
module tb_multicycle_controller;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
  logic [2:0] alu_control_o;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .op_i          (op_i),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .zero_i        (zero_i),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .imm_src_o     (imm_src_o),
    .alu_control_o (alu_control_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result, a, b, imm, alu}
  function automatic logic [15:0] ov(input logic pcw, adr, memw, irw, regw,
                                     input logic [1:0] res, a, b, imm,
                                     input logic [2:0] alu);
    return {pcw, adr, memw, irw, regw, res, a, b, imm, alu};
  endfunction

  function automatic logic [15:0] observed();
    return {pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
            result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o, alu_control_o};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b100:  return 3'd4;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam logic [15:0] V_FETCH  = 16'b1_0_0_1_0_10_00_10_00_000;
  localparam logic [15:0] V_RESET  = 16'b0_0_0_0_0_10_00_10_00_000;
  localparam logic [15:0] V_DECODE = 16'b0_0_0_0_0_00_01_01_10_000;

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unsupported
  task automatic build(input int kind, input logic [2:0] f3, input logic f7,
                       input logic [4:0] z, output logic [15:0] tr[$],
                       output logic [6:0] op);
    tr = {};
    tr.push_back(V_FETCH);
    tr.push_back(V_DECODE);
    case (kind)
      0: begin
        op = 7'b0000011;
        tr.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0));
        tr.push_back(ov(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
        tr.push_back(ov(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      1: begin
        op = 7'b0100011;
        tr.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'd0));
        tr.push_back(ov(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      2: begin
        op = 7'b0110011;
        tr.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, funct_alu(f3, 1'b1, f7)));
        tr.push_back(ov(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      3: begin
        op = 7'b0010011;
        tr.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, funct_alu(f3, 1'b0, f7)));
        tr.push_back(ov(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      4: begin
        op = 7'b1100011;
        tr.push_back(ov(z[2],0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'd1));
      end
      5: begin
        op = 7'b1101111;
        tr.push_back(ov(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'd0));
        tr.push_back(ov(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      default: begin
        do op = 7'($urandom);
        while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111);
      end
    endcase
  endtask

  // Called at a negedge with the FSM in FETCH; returns at a negedge in FETCH.
  task automatic run_instr(input int n, input int kind, input logic [6:0] op_force,
                           input logic use_force, input logic [2:0] f3,
                           input logic f7, input logic [4:0] z);
    logic [15:0] tr[$];
    logic [6:0]  op;
    build(kind, f3, f7, z, tr, op);
    if (use_force) op = op_force;
    op_i = op; funct3_i = f3; funct7b5_i = f7;
    for (int c = 0; c < tr.size(); c++) begin
      zero_i = z[c];
      #1;
      check($sformatf("i%0d k%0d c%0d", n, kind, c), observed(), tr[c]);
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_ni = 1'b0; op_i = '0; funct3_i = '0; funct7b5_i = 1'b0; zero_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("reset_outputs", observed(), V_RESET);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_instr(0, 0, 7'd0, 1'b0, 3'b000, 1'b0, 5'b00000);
    run_instr(1, 2, 7'd0, 1'b0, 3'b000, 1'b1, 5'b00000);
    run_instr(2, 4, 7'd0, 1'b0, 3'b000, 1'b0, 5'b00100);
    run_instr(3, 4, 7'd0, 1'b0, 3'b000, 1'b0, 5'b11011);
    run_instr(4, 1, 7'd0, 1'b0, 3'b010, 1'b0, 5'b00000);
    run_instr(5, 6, 7'b0000000, 1'b1, 3'b000, 1'b0, 5'b00000);
    run_instr(6, 5, 7'd0, 1'b0, 3'b000, 1'b0, 5'b11111);
    run_instr(7, 3, 7'd0, 1'b0, 3'b000, 1'b1, 5'b00000);

    // sw interrupted by reset in the middle of MEMWRITE
    op_i = 7'b0100011; funct3_i = 3'b010; funct7b5_i = 1'b0; zero_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("memwrite_before_rst", observed(), ov(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
    rst_ni = 1'b0;
    #1;
    check("memwrite_async_rst", observed(), V_RESET);
    @(negedge clk_i); #1;
    check("held_in_reset", observed(), V_RESET);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int n = 8; n < 208; n++)
      run_instr(n, int'($urandom_range(0, 6)), 7'd0, 1'b0, 3'($urandom),
                1'($urandom), 5'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
